// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the uart_tx_arbiter slice.
// The LF_START state is only reachable when UART_TX_ARB_CRLF_EN is defined.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT_ACK,
        ST_WAIT_DONE,
        ST_LF_START
    } state_t;

    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester handshake plus transmitter start/data/busy bundle.
// master: arbiter side; slave: requesters and transmitter side.
interface uart_tx_arbiter_if #(
    parameter int unsigned NUM_REQ = 2
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ*8-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ-1:0]   grant;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic                 tx_busy;
    logic                 arb_idle;

    modport master (
        input  req_valid, req_data, tx_busy,
        output req_ready, grant, tx_start, tx_data, arb_idle
    );

    modport slave (
        output req_valid, req_data, tx_busy,
        input  req_ready, grant, tx_start, tx_data, arb_idle
    );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request bit scanning
// ptr, ptr+1, ... modulo NUM_REQ.
module rr_pick #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] winOneHot,
    output logic [PTR_W-1:0]   winIdx,
    output logic               anyReq
);

    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] cand;

    // Scan from the pointer with wrap; the first hit wins.
    always_comb begin
        winOneHot = '0;
        winIdx    = '0;
        anyReq    = 1'b0;
        sum       = '0;
        cand      = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, ptr} + (PTR_W+1)'(i);
            if (sum >= (PTR_W+1)'(NUM_REQ)) begin
                sum = sum - (PTR_W+1)'(NUM_REQ);
            end
            cand = sum[PTR_W-1:0];
            if (!anyReq && req[cand]) begin
                anyReq          = 1'b1;
                winIdx          = cand;
                winOneHot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one 8N2 async transmitter between NUM_REQ
// byte sources. The grant is held until the transmitter drops busy.
// Optional: UART_TX_ARB_CRLF_EN appends an LF frame after every accepted CR.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 2,
    localparam int unsigned PTR_W   = $clog2(NUM_REQ)
) (
    input  logic              clk,
    input  logic              reset_n,
    uart_tx_arbiter_if.master bus
);

    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

    state_t               stateQ, stateD;
    logic [PTR_W-1:0]     ptrQ, ptrD;
    logic [NUM_REQ-1:0]   readyQ, readyD;
    logic [NUM_REQ-1:0]   grantQ, grantD;
    logic                 startQ, startD;
    logic [7:0]           dataQ, dataD;
    logic                 idleQ, idleD;
`ifdef UART_TX_ARB_CRLF_EN
    logic                 crQ, crD;
`endif

    logic [NUM_REQ-1:0]   winOneHot;
    logic [PTR_W-1:0]     winIdx;
    logic                 anyReq;
    logic [7:0]           winData;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req       (bus.req_valid),
        .ptr       (ptrQ),
        .winOneHot (winOneHot),
        .winIdx    (winIdx),
        .anyReq    (anyReq)
    );

    assign winData = bus.req_data[{winIdx, 3'b000} +: 8];

    // Next-state and next-output logic; outputs are registered below, so
    // start/ready are asserted on the transition into START / LF_START.
    always_comb begin
        stateD = stateQ;
        ptrD   = ptrQ;
        readyD = '0;
        grantD = grantQ;
        startD = 1'b0;
        dataD  = dataQ;
`ifdef UART_TX_ARB_CRLF_EN
        crD    = crQ;
`endif
        unique case (stateQ)
            ST_IDLE: begin
                if (anyReq && !bus.tx_busy) begin
                    stateD = ST_START;
                    dataD  = winData;
                    grantD = winOneHot;
                    readyD = winOneHot;
                    startD = 1'b1;
                    ptrD   = (winIdx == LAST_IDX) ? '0 : winIdx + 1'b1;
`ifdef UART_TX_ARB_CRLF_EN
                    crD    = (winData == CHAR_CR);
`endif
                end
            end
            ST_START: begin
                stateD = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (bus.tx_busy) begin
                    stateD = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (!bus.tx_busy) begin
`ifdef UART_TX_ARB_CRLF_EN
                    if (crQ) begin
                        stateD = ST_LF_START;
                        dataD  = CHAR_LF;
                        startD = 1'b1;
                        crD    = 1'b0;
                    end else begin
                        stateD = ST_IDLE;
                        grantD = '0;
                    end
`else
                    stateD = ST_IDLE;
                    grantD = '0;
`endif
                end
            end
`ifdef UART_TX_ARB_CRLF_EN
            ST_LF_START: begin
                stateD = ST_WAIT_ACK;
            end
`endif
            default: begin
                stateD = ST_IDLE;
                grantD = '0;
            end
        endcase
        idleD = (stateD == ST_IDLE);
    end

    // State and registered outputs, cleared asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stateQ <= ST_IDLE;
            ptrQ   <= '0;
            readyQ <= '0;
            grantQ <= '0;
            startQ <= 1'b0;
            dataQ  <= 8'h00;
            idleQ  <= 1'b1;
`ifdef UART_TX_ARB_CRLF_EN
            crQ    <= 1'b0;
`endif
        end else begin
            stateQ <= stateD;
            ptrQ   <= ptrD;
            readyQ <= readyD;
            grantQ <= grantD;
            startQ <= startD;
            dataQ  <= dataD;
            idleQ  <= idleD;
`ifdef UART_TX_ARB_CRLF_EN
            crQ    <= crD;
`endif
        end
    end

    assign bus.req_ready = readyQ;
    assign bus.grant     = grantQ;
    assign bus.tx_start  = startQ;
    assign bus.tx_data   = dataQ;
    assign bus.arb_idle  = idleQ;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (3 requesters). Checks follow
// UART_TX_ARB_CRLF_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    localparam int unsigned N = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

    uart_tx_arbiter #(.NUM_REQ(N)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int unsigned total = 0;
    int unsigned bad   = 0;

`ifdef UART_TX_ARB_CRLF_EN
    localparam bit CRLF = 1'b1;
`else
    localparam bit CRLF = 1'b0;
`endif

    // Transmitter stand-in: busy rises the edge after start, lasts frameLen cycles.
    logic        xmitBusy;
    logic        forceBusy = 1'b0;
    int unsigned busyCnt;
    int unsigned frameLen = 10;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            xmitBusy <= 1'b0;
            busyCnt  <= 0;
        end else if (bus.tx_start) begin
            xmitBusy <= 1'b1;
            busyCnt  <= frameLen;
        end else if (busyCnt > 1) begin
            busyCnt  <= busyCnt - 1;
        end else begin
            xmitBusy <= 1'b0;
            busyCnt  <= 0;
        end
    end
    always_comb bus.tx_busy = xmitBusy | forceBusy;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned    cyc;
        logic [N-1:0]   grant;
        logic [N-1:0]   ready;
        logic [7:0]     data;
    } ev_t;

    ev_t         startLog[$];
    int unsigned readyPulses = 0;

    // Log every start pulse and count ready pulses.
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.tx_start) startLog.push_back('{cyc, bus.grant, bus.req_ready, bus.tx_data});
            if (bus.req_ready != '0) readyPulses++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic doReset();
        bus.req_valid = '0;
        bus.req_data  = '0;
        forceBusy     = 1'b0;
        tick();
        reset_n = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        startLog.delete();
        readyPulses = 0;
    endtask

    task automatic waitStarts(input int unsigned n, input int unsigned maxCyc, output bit ok);
        ok = 1'b0;
        for (int unsigned i = 0; i < maxCyc; i++) begin
            if (startLog.size() >= n) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
        ok = (startLog.size() >= n);
    endtask

    task automatic waitIdle(input int unsigned maxCyc, output bit ok);
        ok = 1'b0;
        for (int unsigned i = 0; i < maxCyc; i++) begin
            tick();
            if (bus.arb_idle && !bus.tx_busy) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        tick();
        reset_n = 1'b0;
        #1;
        total++; if (bus.req_ready !== '0) begin bad++; $display("FAIL reset_ready: got %b want 000", bus.req_ready); end
        total++; if (bus.grant !== '0) begin bad++; $display("FAIL reset_grant: got %b want 000", bus.grant); end
        total++; if (bus.tx_start !== 1'b0) begin bad++; $display("FAIL reset_start: got %b want 0", bus.tx_start); end
        total++; if (bus.tx_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", bus.tx_data); end
        total++; if (bus.arb_idle !== 1'b1) begin bad++; $display("FAIL reset_idle: got %b want 1", bus.arb_idle); end
        bus.req_valid = '0;
        bus.req_data  = '0;
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (3) tick();
        total++; if (bus.arb_idle !== 1'b1 || bus.grant !== '0) begin
            bad++; $display("FAIL reset_quiet: idle=%b grant=%b want idle=1 grant=000", bus.arb_idle, bus.grant);
        end
        startLog.delete();
        readyPulses = 0;
    endtask

    task automatic test_single();
        bit ok;
        bit seenBusy;
        int unsigned t0, holdErr;
        doReset();
        frameLen = 10;
        bus.req_data[7:0] = 8'h41;
        bus.req_valid     = 3'b001;
        t0 = cyc;
        waitStarts(1, 20, ok);
        bus.req_valid = '0;
        total++; if (!ok) begin bad++; $display("FAIL single_start: got no start want one"); end
        if (ok) begin
            total++; if (startLog[0].cyc !== t0 + 1) begin bad++; $display("FAIL single_latency: got cyc %0d want %0d", startLog[0].cyc, t0 + 1); end
            total++; if (startLog[0].ready !== 3'b001) begin bad++; $display("FAIL single_ready: got %b want 001", startLog[0].ready); end
            total++; if (startLog[0].data !== 8'h41) begin bad++; $display("FAIL single_data: got %h want 41", startLog[0].data); end
            total++; if (startLog[0].grant !== 3'b001) begin bad++; $display("FAIL single_grant: got %b want 001", startLog[0].grant); end
        end
        seenBusy = 1'b0;
        holdErr  = 0;
        ok       = 1'b0;
        for (int unsigned i = 0; i < 40; i++) begin
            tick();
            if (bus.tx_busy) seenBusy = 1'b1;
            else if (seenBusy) begin ok = 1'b1; break; end
            if (bus.grant !== 3'b001 || bus.tx_data !== 8'h41 || bus.arb_idle !== 1'b0) holdErr++;
        end
        total++; if (!ok || holdErr != 0) begin bad++; $display("FAIL single_hold: got done=%b errs=%0d want done=1 errs=0", ok, holdErr); end
        total++; if (bus.grant !== 3'b001 || bus.arb_idle !== 1'b0) begin
            bad++; $display("FAIL single_busyfall: grant=%b idle=%b want 001/0", bus.grant, bus.arb_idle);
        end
        tick();
        total++; if (bus.grant !== '0 || bus.arb_idle !== 1'b1) begin
            bad++; $display("FAIL single_release: grant=%b idle=%b want 000/1", bus.grant, bus.arb_idle);
        end
    endtask

    task automatic test_contention();
        bit ok;
        logic [7:0]   wantD;
        logic [N-1:0] wantR;
        doReset();
        frameLen = 4;
        bus.req_data[7:0]  = 8'h30;
        bus.req_data[15:8] = 8'h31;
        bus.req_valid      = 3'b011;
        waitStarts(4, 200, ok);
        bus.req_valid = '0;
        waitIdle(100, ok);
        total++; if (startLog.size() != 4) begin bad++; $display("FAIL contention_count: got %0d want 4", startLog.size()); end
        for (int unsigned k = 0; k < 4 && k < startLog.size(); k++) begin
            wantD = (k % 2 == 1) ? 8'h31 : 8'h30;
            wantR = (k % 2 == 1) ? 3'b010 : 3'b001;
            total++; if (startLog[k].data !== wantD || startLog[k].ready !== wantR) begin
                bad++; $display("FAIL contention_frame%0d: got %h/%b want %h/%b", k, startLog[k].data, startLog[k].ready, wantD, wantR);
            end
        end
    endtask

    task automatic test_busy_entry();
        bit ok;
        int unsigned t0;
        doReset();
        frameLen = 3;
        forceBusy = 1'b1;
        bus.req_data[7:0] = 8'h55;
        bus.req_valid     = 3'b001;
        repeat (6) tick();
        total++; if (startLog.size() != 0 || readyPulses != 0) begin
            bad++; $display("FAIL busy_hold: got starts=%0d readies=%0d want 0/0", startLog.size(), readyPulses);
        end
        forceBusy = 1'b0;
        t0 = cyc;
        waitStarts(1, 10, ok);
        bus.req_valid = '0;
        total++; if (!ok || startLog[0].cyc !== t0 + 1 || startLog[0].data !== 8'h55) begin
            bad++; $display("FAIL busy_release: got start=%b data=%h want start at %0d data 55", ok, ok ? startLog[0].data : 8'h00, t0 + 1);
        end
        waitIdle(50, ok);
    endtask

    task automatic test_stale_valid();
        bit ok;
        int unsigned idleCyc;
        doReset();
        frameLen = 5;
        bus.req_data[7:0] = 8'h60;
        bus.req_valid     = 3'b001;
        waitStarts(1, 20, ok);
        idleCyc = 0;
        for (int unsigned i = 0; i < 50; i++) begin
            tick();
            if (bus.arb_idle) begin idleCyc = cyc; break; end
        end
        total++; if (idleCyc == 0 || readyPulses != 1) begin
            bad++; $display("FAIL stale_single: got idleCyc=%0d readies=%0d want idle seen and 1 ready", idleCyc, readyPulses);
        end
        waitStarts(2, 20, ok);
        bus.req_valid = '0;
        total++; if (!ok || startLog[1].cyc !== idleCyc + 1) begin
            bad++; $display("FAIL stale_next: got ok=%b cyc=%0d want cyc %0d", ok, ok ? startLog[1].cyc : 0, idleCyc + 1);
        end
        waitIdle(50, ok);
        total++; if (readyPulses != 2 || startLog.size() != 2) begin
            bad++; $display("FAIL stale_count: got readies=%0d starts=%0d want 2/2", readyPulses, startLog.size());
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        doReset();
        frameLen = 10;
        bus.req_data[7:0]  = 8'h30;
        bus.req_data[15:8] = 8'h31;
        bus.req_valid      = 3'b011;
        waitStarts(1, 20, ok);
        repeat (4) tick();
        reset_n = 1'b0;
        #1;
        total++; if (bus.grant !== '0 || bus.arb_idle !== 1'b1 || bus.tx_data !== 8'h00 || bus.tx_start !== 1'b0 || bus.req_ready !== '0) begin
            bad++; $display("FAIL midreset_outputs: grant=%b idle=%b data=%h want 000/1/00", bus.grant, bus.arb_idle, bus.tx_data);
        end
        repeat (2) tick();
        reset_n = 1'b1;
        startLog.delete();
        readyPulses = 0;
        waitStarts(1, 20, ok);
        bus.req_valid = '0;
        total++; if (!ok || startLog[0].grant !== 3'b001 || startLog[0].data !== 8'h30) begin
            bad++; $display("FAIL midreset_ptr: got ok=%b grant=%b want 001 data 30", ok, ok ? startLog[0].grant : 3'b000);
        end
        waitIdle(50, ok);
    endtask

    task automatic test_crlf();
        bit ok;
        int unsigned holdErr;
        doReset();
        frameLen = 3;
        bus.req_data[7:0] = 8'h0D;
        bus.req_valid     = 3'b001;
        waitStarts(1, 20, ok);
        bus.req_valid = '0;
        holdErr = 0;
        ok = 1'b0;
        for (int unsigned i = 0; i < 60; i++) begin
            tick();
            if (bus.arb_idle) begin ok = 1'b1; break; end
            if (bus.grant !== 3'b001) holdErr++;
        end
        total++; if (!ok || holdErr != 0) begin bad++; $display("FAIL crlf_grant: got done=%b errs=%0d want 1/0", ok, holdErr); end
        total++; if (readyPulses != 1) begin bad++; $display("FAIL crlf_ready: got %0d want 1", readyPulses); end
        if (CRLF) begin
            total++; if (startLog.size() != 2) begin bad++; $display("FAIL crlf_count: got %0d want 2", startLog.size()); end
            else begin
                total++; if (startLog[0].data !== 8'h0D || startLog[1].data !== 8'h0A || startLog[1].ready !== '0 || startLog[1].grant !== 3'b001) begin
                    bad++; $display("FAIL crlf_frames: got %h,%h ready2=%b want 0d,0a ready2=000", startLog[0].data, startLog[1].data, startLog[1].ready);
                end
            end
        end else begin
            total++; if (startLog.size() != 1 || startLog[0].data !== 8'h0D) begin
                bad++; $display("FAIL crlf_plain: got %0d frames want one 0d frame", startLog.size());
            end
        end
    endtask

    task automatic test_random();
        logic [7:0]   qd [N][4];
        int unsigned  qlen [N];
        int unsigned  head [N];
        int unsigned  pos [N];
        ev_t          exp[$];
        logic [N-1:0] oh;
        logic [7:0]   b;
        int unsigned  p, w, r;
        bit           found, done, ok;
        for (int unsigned round = 0; round < 25; round++) begin
            doReset();
            frameLen = $urandom_range(1, 6);
            for (int unsigned i = 0; i < N; i++) begin
                qlen[i] = $urandom_range(0, 4);
                head[i] = 0;
                pos[i]  = 0;
                for (int unsigned j = 0; j < 4; j++) begin
                    r = $urandom_range(0, 7);
                    qd[i][j] = (r == 0) ? 8'h0D : (r == 1) ? 8'h0A : 8'($urandom);
                end
            end
            // Expected order: every pending source visible at each decision, served round-robin from 0.
            exp.delete();
            p = 0;
            forever begin
                found = 1'b0;
                w = 0;
                for (int unsigned k = 0; k < N; k++) begin
                    w = (p + k) % N;
                    if (pos[w] < qlen[w]) begin found = 1'b1; break; end
                end
                if (!found) break;
                b = qd[w][pos[w]];
                pos[w]++;
                oh = '0;
                oh[w] = 1'b1;
                exp.push_back('{0, oh, oh, b});
                if (CRLF && b == 8'h0D) exp.push_back('{0, oh, '0, 8'h0A});
                p = (w + 1) % N;
            end
            for (int unsigned i = 0; i < N; i++) begin
                bus.req_valid[i]      = (head[i] < qlen[i]);
                bus.req_data[i*8 +: 8] = qd[i][0];
            end
            done = 1'b0;
            for (int unsigned c = 0; c < 2000 && !done; c++) begin
                tick();
                for (int unsigned i = 0; i < N; i++) begin
                    if (bus.req_ready[i]) begin
                        head[i]++;
                        bus.req_valid[i] = (head[i] < qlen[i]);
                        if (head[i] < qlen[i]) bus.req_data[i*8 +: 8] = qd[i][head[i]];
                    end
                end
                done = 1'b1;
                for (int unsigned i = 0; i < N; i++) if (head[i] < qlen[i]) done = 1'b0;
            end
            waitIdle(100, ok);
            total++; if (!done || !ok || startLog.size() != exp.size()) begin
                bad++; $display("FAIL random%0d_count: got %0d frames done=%b want %0d", round, startLog.size(), done, exp.size());
            end else begin
                for (int unsigned k = 0; k < exp.size(); k++) begin
                    total++; if (startLog[k].data !== exp[k].data || startLog[k].grant !== exp[k].grant || startLog[k].ready !== exp[k].ready) begin
                        bad++; $display("FAIL random%0d_frame%0d: got %h/%b/%b want %h/%b/%b", round, k,
                            startLog[k].data, startLog[k].grant, startLog[k].ready, exp[k].data, exp[k].grant, exp[k].ready);
                    end
                end
            end
        end
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_data  = '0;
        test_reset();
        test_single();
        test_contention();
        test_busy_entry();
        test_stale_valid();
        test_reset_mid();
        test_crlf();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
